d_mem_ctrl: RTL
===============

Name: d_mem_ctrl

Overview:
- Parametrised, clocked successor to the single-cycle data memory of the MIPS datapath.
- Services one load/store at a time over a req/ready handshake with configurable wait-state latency.
- Supports byte, halfword and word accesses with sign or zero extension on loads, and reports alignment and range errors.
- Sits between the MEM stage and the data RAM. A done pulse tells the stall logic when to release the pipeline.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; the address range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 1: wait cycles between accept and response; range 0..15.
- INIT_ZERO, 1: 1 = memory is zero-filled at time zero (simulation initial); 0 = contents are undefined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only while ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- ready  out  1  high in IDLE only; a request is accepted when req & ready.
- busy  out  1  high in WAIT and RESP.
- done  out  1  one-cycle pulse at completion.
- rdata  out  32  load result; valid when done=1 and held until the next done.
- err  out  1  valid with done: 1 = misaligned, reserved size, or out of range.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, err=0, rdata=0, wait counter=0. Memory contents are not altered by reset.
- Registered outputs: done, err, rdata. ready and busy decode directly from state.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req=1, latch we/size/sign_ext/addr/wdata. Next state is RESP if LATENCY=0 or the access is an error; otherwise WAIT with counter=LATENCY-1.
  - WAIT: if counter=0, go to RESP; otherwise decrement the counter.
  - RESP: done=1 for exactly this cycle, then return to IDLE.
- Throughput: ready is low in RESP, so back-to-back requests are separated by at least one cycle.
- Latency: accept edge to done=1 is LATENCY+1 cycles.
- Error detection (evaluated on the latched request):
  - misaligned: size=01 with addr[0]=1, or size=10 with addr[1:0]!=0;
  - size=11;
  - addr[31:2] >= DEPTH_WORDS.
  - On error: no write and no read; err=1 with done; rdata holds its previous value.
- Memory commit: the write, or the rdata update, happens on the clock edge entering RESP. Errors skip the WAIT cycles.
- Byte lanes are little-endian, lane k = bits [8k+7:8k]:
  - sb: writes lane addr[1:0];
  - sh: writes lanes {addr[1],0} and {addr[1],1};
  - sw: writes all four lanes.
  - Unselected lanes are preserved.
- Loads: extract the selected byte or halfword, then extend to 32 bits per sign_ext. Word loads ignore sign_ext.
- Stores: rdata is unchanged and err=0 on success.
- Inputs while not IDLE: req and the other inputs are ignored; the latched request is used throughout.
- Reset mid-operation: asserting rst_n=0 in WAIT aborts the access. A pending store is not written and no done is produced.
- Wrap-around: none. Addresses beyond the range are errors, never aliased.

Test Plan:
- sw 0x00000004 ← 0xA5A5A5A5, then lw 0x00000004 → done after LATENCY+1 cycles, rdata=0xA5A5A5A5, err=0.
- sw 0x8 ← 0x12345678; sb 0x9 ← 0xEE; lw 0x8 → 0x1234EE78. Then lb 0x9 sign_ext=1 → 0xFFFFFFEE; lbu 0x9 → 0x000000EE; lh 0xA sign_ext=1 → 0x00001234.
- lw 0x6 → err=1 with done after 1 cycle (no WAIT); sh 0x3 → err=1 with memory unchanged; lw 4*DEPTH_WORDS → err=1.
- LATENCY=3 build: req at cycle 0 → ready=0 for cycles 1..4, done at cycle 4. req toggled during busy → ignored, no extra done.
- sw 0x10 ← 0xDEADBEEF, then rst_n=0 during WAIT → outputs reset, no done; a later lw 0x10 returns the prior contents (0 with INIT_ZERO=1).
- Two back-to-back requests with req held high → second accepted the cycle after done, both complete with correct data.

Source files
------------

// File: rtl/d_mem_ctrl.sv
// Clocked data memory for the MEM stage: one load/store at a time over req/ready.
// Done is a one-cycle pulse LATENCY+1 cycles after accept (1 cycle for errors); ready is low while busy.
module d_mem_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1,
   parameter bit INIT_ZERO   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        commit;

   logic        we_q, sign_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;

   logic        cur_we, cur_sign, cur_err;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr, cur_wdata;
   logic [AW-1:0] widx;
   logic [31:0] rd_word, ld_val, st_dat;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [3:0]  lanes;

   logic [31:0] mem [DEPTH_WORDS] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

   // In IDLE the live inputs are used so a LATENCY=0 or error access can commit on its accept edge.
   assign cur_we    = (state == IDLE) ? we       : we_q;
   assign cur_size  = (state == IDLE) ? size     : size_q;
   assign cur_sign  = (state == IDLE) ? sign_ext : sign_q;
   assign cur_addr  = (state == IDLE) ? addr     : addr_q;
   assign cur_wdata = (state == IDLE) ? wdata    : wdata_q;

   assign cur_err = (cur_size == 2'b11)
                  | ((cur_size == 2'b01) & cur_addr[0])
                  | ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00))
                  | (cur_addr[31:2] >= 30'(DEPTH_WORDS));

   assign widx    = cur_addr[AW+1:2];
   assign rd_word = mem[widx];
   assign rd_byte = rd_word[8*cur_addr[1:0] +: 8];
   assign rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      ld_val = rd_word;
      st_dat = cur_wdata;
      lanes  = 4'b1111;
      case (cur_size)
         2'b00: begin
            ld_val = {{24{cur_sign & rd_byte[7]}}, rd_byte};
            st_dat = {4{cur_wdata[7:0]}};
            case (cur_addr[1:0])
               2'd0:    lanes = 4'b0001;
               2'd1:    lanes = 4'b0010;
               2'd2:    lanes = 4'b0100;
               default: lanes = 4'b1000;
            endcase
         end
         2'b01: begin
            ld_val = {{16{cur_sign & rd_half[15]}}, rd_half};
            st_dat = {2{cur_wdata[15:0]}};
            lanes  = cur_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      case (state)
         IDLE: if (req) begin
            if (LATENCY == 0 || cur_err) begin
               state_nxt = RESP;
               commit    = 1'b1;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = 4'(LATENCY - 1);
            end
         end
         WAIT: if (cnt == 4'd0) begin
            state_nxt = RESP;
            commit    = 1'b1;
         end else begin
            cnt_nxt = cnt - 4'd1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'h0;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= commit;
         if (state == IDLE && req) begin
            we_q    <= we;
            sign_q  <= sign_ext;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (commit) begin
            err <= cur_err;
            if (!cur_err && !cur_we)
               rdata <= ld_val;
         end
      end
   end

   // Memory is outside the reset domain: an aborted access never reaches commit.
   always_ff @(posedge clk) begin
      if (commit && cur_we && !cur_err) begin
         for (int k = 0; k < 4; k++)
            if (lanes[k])
               mem[widx][8*k +: 8] <= st_dat[8*k +: 8];
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);

endmodule
